// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one operation
// in flight, issued for one cycle, result captured after a command-dependent latency.
module alu_req_arbiter #(
  parameter int OP_W    = 8,
  parameter int CMD_W   = 4,
  parameter int RES_W   = 2 * OP_W,
  parameter int LAT     = 1,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  // requester 0
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic             r0_mode,
  input  logic             r0_cin,
  input  logic [1:0]       r0_inp_valid,
  input  logic [CMD_W-1:0] r0_cmd,
  input  logic [OP_W-1:0]  r0_opa,
  input  logic [OP_W-1:0]  r0_opb,
  // requester 1
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic             r1_mode,
  input  logic             r1_cin,
  input  logic [1:0]       r1_inp_valid,
  input  logic [CMD_W-1:0] r1_cmd,
  input  logic [OP_W-1:0]  r1_opa,
  input  logic [OP_W-1:0]  r1_opb,
  // ALU side
  output logic             alu_ce,
  output logic             alu_mode,
  output logic             alu_cin,
  output logic [1:0]       alu_inp_valid,
  output logic [CMD_W-1:0] alu_cmd,
  output logic [OP_W-1:0]  alu_opa,
  output logic [OP_W-1:0]  alu_opb,
  input  logic [RES_W-1:0] alu_res,
  input  logic             alu_cout,
  input  logic             alu_oflow,
  input  logic             alu_g,
  input  logic             alu_l,
  input  logic             alu_e,
  input  logic             alu_err,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [RES_W-1:0] rsp_res,
  output logic [5:0]       rsp_flags
);

  localparam int MAX_LAT = (LAT > MUL_LAT) ? LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] MUL_C = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic             mode;
    logic             cin;
    logic [1:0]       inp_valid;
    logic [CMD_W-1:0] cmd;
    logic [OP_W-1:0]  opa;
    logic [OP_W-1:0]  opb;
  } op_t;

  state_e           state_q, state_d;
  op_t              op_q, op_d, op_in;
  logic             id_q, id_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alu_ce_q, alu_ce_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0] rsp_res_q, rsp_res_d;
  logic [5:0]       rsp_flags_q, rsp_flags_d;

  logic gnt_vld, gnt_id, accept, is_mul;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (state_q == S_IDLE) begin
      if (r0_valid && r1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = rr_q;
      end else if (r0_valid) begin
        gnt_vld = 1'b1;
      end else if (r1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  // Gated by rst so ready stays low while reset is held even though state reads IDLE.
  assign r0_ready = rst & gnt_vld & ~gnt_id;
  assign r1_ready = rst & gnt_vld &  gnt_id;
  assign accept   = r0_ready | r1_ready;

  assign op_in = gnt_id ? op_t'{r1_mode, r1_cin, r1_inp_valid, r1_cmd, r1_opa, r1_opb}
                        : op_t'{r0_mode, r0_cin, r0_inp_valid, r0_cmd, r0_opa, r0_opb};

  assign is_mul = op_q.mode && ((op_q.cmd == CMD_W'(9)) || (op_q.cmd == CMD_W'(10)));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    id_d        = id_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    alu_ce_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_res_d   = rsp_res_q;
    rsp_flags_d = rsp_flags_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = op_in;
          id_d     = gnt_id;
          alu_ce_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = is_mul ? MUL_C : LAT_C;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - ONE_C;
        if (cnt_q == ONE_C) begin
          rsp_res_d   = alu_res;
          rsp_flags_d = {alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err};
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_d        = ~id_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the operation latch is
  // reset too because it drives the ALU bus, which must read zero during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      id_q        <= 1'b0;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      alu_ce_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      alu_ce_q    <= alu_ce_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign alu_ce        = alu_ce_q;
  assign alu_mode      = op_q.mode;
  assign alu_cin       = op_q.cin;
  assign alu_inp_valid = op_q.inp_valid;
  assign alu_cmd       = op_q.cmd;
  assign alu_opa       = op_q.opa;
  assign alu_opb       = op_q.opb;

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter: a latency-accurate ALU model drives garbage
// except in the exact cycle its result is due, so mistimed capture is visible.
module tb_alu_req_arbiter;

  localparam int OP_W  = 8;
  localparam int CMD_W = 4;
  localparam int RES_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             r0_valid, r0_ready, r0_mode, r0_cin;
  logic [1:0]       r0_inp_valid;
  logic [CMD_W-1:0] r0_cmd;
  logic [OP_W-1:0]  r0_opa, r0_opb;
  logic             r1_valid, r1_ready, r1_mode, r1_cin;
  logic [1:0]       r1_inp_valid;
  logic [CMD_W-1:0] r1_cmd;
  logic [OP_W-1:0]  r1_opa, r1_opb;
  logic             alu_ce, alu_mode, alu_cin;
  logic [1:0]       alu_inp_valid;
  logic [CMD_W-1:0] alu_cmd;
  logic [OP_W-1:0]  alu_opa, alu_opb;
  logic [RES_W-1:0] alu_res;
  logic             alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [RES_W-1:0] rsp_res;
  logic [5:0]       rsp_flags;

  always #5 clk = ~clk;

  alu_req_arbiter #(.OP_W(OP_W), .CMD_W(CMD_W), .RES_W(RES_W), .LAT(1), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_mode(r0_mode), .r0_cin(r0_cin),
    .r0_inp_valid(r0_inp_valid), .r0_cmd(r0_cmd), .r0_opa(r0_opa), .r0_opb(r0_opb),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_mode(r1_mode), .r1_cin(r1_cin),
    .r1_inp_valid(r1_inp_valid), .r1_cmd(r1_cmd), .r1_opa(r1_opa), .r1_opb(r1_opb),
    .alu_ce(alu_ce), .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_inp_valid(alu_inp_valid),
    .alu_cmd(alu_cmd), .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_res(alu_res),
    .alu_cout(alu_cout), .alu_oflow(alu_oflow), .alu_g(alu_g), .alu_l(alu_l),
    .alu_e(alu_e), .alu_err(alu_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags)
  );

  typedef struct {
    logic             id;
    logic [RES_W-1:0] res;
    logic [5:0]       flags;
    int               lat;
    int               acc_cyc;
    logic [OP_W-1:0]  opa;
  } exp_t;

  exp_t             sb[$];
  int               acc_hist[$];
  logic             grant_hist[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               cyc = 0;
  int               last_acc_cyc = -10;
  logic             prev_rsp_valid = 1'b0;
  logic [RES_W-1:0] last_res = '0;
  logic [5:0]       last_flags = '0;
  logic             last_id = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ALU reference: {cout,oflow,g,l,e,err, result}
  function automatic logic [RES_W+5:0] alu_fn(input logic mode, input logic cin,
      input logic [1:0] iv, input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic [5:0]  f;
    if (mode && cmd == 4'd0)                       r = {8'h00, a} + {8'h00, b} + {15'h0, cin};
    else if (mode && cmd == 4'd1)                  r = {8'h00, a} - {8'h00, b};
    else if (mode && (cmd == 4'd9 || cmd == 4'd10)) r = 16'(a) * 16'(b);
    else                                           r = {a ^ b, a & b};
    f = {r[8], 1'b0, a > b, a < b, a == b, (iv != 2'b11) || (cmd > 4'd13)};
    return {f, r};
  endfunction

  function automatic exp_t mk_exp(input logic id, input logic mode, input logic cin,
      input logic [1:0] iv, input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
      input int c);
    exp_t e;
    logic [RES_W+5:0] v;
    v         = alu_fn(mode, cin, iv, cmd, a, b);
    e.id      = id;
    e.res     = v[RES_W-1:0];
    e.flags   = v[RES_W+5:RES_W];
    e.lat     = (mode && (cmd == 4'd9 || cmd == 4'd10)) ? 2 : 1;
    e.acc_cyc = c;
    e.opa     = a;
    return e;
  endfunction

  // ALU model: result valid only in the cycle it is due, inverted garbage otherwise.
  logic [RES_W+5:0] pend = '0;
  int               pend_cnt = 0;
  always @(posedge clk) begin
    if (alu_ce) begin
      pend     <= alu_fn(alu_mode, alu_cin, alu_inp_valid, alu_cmd, alu_opa, alu_opb);
      pend_cnt <= (alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10)) ? 2 : 1;
    end else if (pend_cnt > 0) begin
      pend_cnt <= pend_cnt - 1;
    end
  end
  assign {alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err, alu_res} =
         (pend_cnt == 1) ? pend : ~pend;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (r0_ready || r1_ready) begin
        check("ready_onehot", r0_ready & r1_ready, 0);
        check("ready_while_busy", sb.size(), 0);
      end
      if (r0_valid && r0_ready) begin
        sb.push_back(mk_exp(1'b0, r0_mode, r0_cin, r0_inp_valid, r0_cmd, r0_opa, r0_opb, cyc));
        last_acc_cyc = cyc;
        acc_hist.push_back(cyc);
        grant_hist.push_back(1'b0);
      end else if (r1_valid && r1_ready) begin
        sb.push_back(mk_exp(1'b1, r1_mode, r1_cin, r1_inp_valid, r1_cmd, r1_opa, r1_opb, cyc));
        last_acc_cyc = cyc;
        acc_hist.push_back(cyc);
        grant_hist.push_back(1'b1);
      end
      if (alu_ce) begin
        check("alu_ce_cycle", cyc, last_acc_cyc + 1);
        if (sb.size() > 0) check("alu_opa", alu_opa, sb[0].opa);
      end
      if (rsp_valid && !prev_rsp_valid) begin
        if (sb.size() > 0) check("rsp_latency", cyc - sb[0].acc_cyc, 2 + sb[0].lat);
        else               check("rsp_unexpected", sb.size(), 1);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_res", rsp_res, e.res);
          check("rsp_flags", rsp_flags, e.flags);
        end else begin
          check("rsp_unexpected", sb.size(), 1);
        end
        last_res   = rsp_res;
        last_flags = rsp_flags;
        last_id    = rsp_id;
      end
    end
    prev_rsp_valid = rsp_valid;
  end

  task automatic check_zero(input string tag);
    check(tag, {alu_ce, alu_mode, alu_cin, alu_inp_valid, alu_cmd, alu_opa, alu_opb,
                rsp_valid, rsp_id, rsp_res, rsp_flags, r0_ready, r1_ready}, 64'd0);
  endtask

  task automatic set_req(input logic id, input logic mode, input logic cin, input logic [1:0] iv,
                         input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      r1_mode = mode; r1_cin = cin; r1_inp_valid = iv; r1_cmd = cmd; r1_opa = a; r1_opb = b;
    end else begin
      r0_mode = mode; r0_cin = cin; r0_inp_valid = iv; r0_cmd = cmd; r0_opa = a; r0_opb = b;
    end
  endtask

  task automatic drive_req(input logic id, input logic mode, input logic cin, input logic [1:0] iv,
                           input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    set_req(id, mode, cin, iv, cmd, a, b);
    if (id) r1_valid = 1'b1; else r0_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (id ? r1_ready : r0_ready) ok = 1'b1;
    end
    check("accept_timeout", ok, 1);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !rsp_valid) ok = 1'b1;
    end
    check({tag, "_done"}, ok, 1);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_zero(tag);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit               ok;
    int               n0;
    logic [RES_W+6:0] held;
    r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 8'h00);

    // Reset: outputs zero, ready suppressed even with a valid request present
    r0_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_outs");
    r0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single op: 5 + 3
    drive_req(1'b0, 1'b1, 1'b0, 2'b11, 4'd0, 8'h05, 8'h03);
    wait_done("single");
    check("single_res", last_res, 16'd8);
    check("single_id", last_id, 0);

    // Contention from reset: r0, r1, r0, r1
    do_reset("reset_pre_contention");
    acc_hist.delete();
    grant_hist.delete();
    set_req(1'b0, 1'b1, 1'b0, 2'b11, 4'd0, 8'd10, 8'd20);
    set_req(1'b1, 1'b1, 1'b0, 2'b11, 4'd9, 8'd7, 8'd6);
    r0_valid = 1'b1; r1_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); #1;
      if (acc_hist.size() >= 4) ok = 1'b1;
    end
    @(posedge clk); #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    check("contention_grants", ok, 1);
    if (ok) begin
      check("grant_order", {grant_hist[0], grant_hist[1], grant_hist[2], grant_hist[3]}, 4'b0101);
      check("period_add", acc_hist[1] - acc_hist[0], 4);
      check("period_mul", acc_hist[2] - acc_hist[1], 5);
    end
    wait_done("contention");

    // Multiply latency on r1: 0xFF * 0x02
    drive_req(1'b1, 1'b1, 1'b0, 2'b11, 4'd9, 8'hFF, 8'h02);
    wait_done("mul");
    check("mul_res", last_res, 16'h01FE);
    check("mul_id", last_id, 1);

    // Response backpressure with both requesters waiting
    rsp_ready = 1'b0;
    drive_req(1'b0, 1'b1, 1'b0, 2'b11, 4'd1, 8'h40, 8'h11);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    check("bp_rsp_seen", ok, 1);
    held = {rsp_id, rsp_res, rsp_flags};
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 2'b11, 4'd0, 8'h01, 8'h01);
    set_req(1'b1, 1'b1, 1'b0, 2'b11, 4'd0, 8'h02, 8'h02);
    r0_valid = 1'b1; r1_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_payload", {rsp_id, rsp_res, rsp_flags}, held);
      check("bp_no_ready", r0_ready | r1_ready, 0);
    end
    @(posedge clk); #1;
    r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_complete", rsp_valid, 0);
    check("bp_res", last_res, 16'h002F);

    // Reset during WAIT of a multiply
    drive_req(1'b0, 1'b1, 1'b0, 2'b11, 4'd10, 8'h12, 8'h34);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (alu_ce) ok = 1'b1;
    end
    check("midwait_issue_seen", ok, 1);
    do_reset("reset_mid_wait");
    repeat (4) begin
      @(negedge clk);
      check("no_stale_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    n0 = acc_hist.size();
    set_req(1'b0, 1'b1, 1'b0, 2'b11, 4'd0, 8'h21, 8'h01);
    set_req(1'b1, 1'b1, 1'b0, 2'b11, 4'd0, 8'h31, 8'h02);
    r0_valid = 1'b1; r1_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); #1;
      if (acc_hist.size() > n0) ok = 1'b1;
    end
    @(posedge clk); #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    check("rr_grant_seen", ok, 1);
    if (ok) check("rr_after_reset", grant_hist[$], 0);
    wait_done("rr_after_reset");
    drive_req(1'b1, 1'b1, 1'b0, 2'b11, 4'd0, 8'h0A, 8'h0B);
    wait_done("r1_after_reset");
    check("r1_after_reset_id", last_id, 1);
    check("r1_after_reset_res", last_res, 16'h0015);

    // Error pass-through: no operands valid
    drive_req(1'b0, 1'b1, 1'b0, 2'b00, 4'd0, 8'h01, 8'h02);
    wait_done("err");
    check("err_flag", last_flags[0], 1);

    // A few random operations
    for (int k = 0; k < 6; k++) begin
      drive_req(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)),
                8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
      wait_done("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
